// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of a shared 32-bit barrel shifter.
// The result sits in a one-entry output buffer that honours backpressure.
module shift_arbiter #(
    parameter bit RR_INIT = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_data,
    input  logic [4:0]       req0_shamt,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_data,
    input  logic [4:0]       req1_shamt,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t state_reg;
    buf_state_t state_next;
    logic       prio_reg;
    logic       can_accept;
    logic       grant0;
    logic       grant1;
    logic       accept;

    logic [31:0] sel_data;
    logic [4:0]  sel_shamt;
    logic [1:0]  sel_op;
    logic        dir_left;
    logic        fill_bit;
    logic [31:0] shift_in;
    logic [31:0] shift_out;
    logic [31:0] result;
    logic [31:0] stage [0:5];

    assign rsp_valid  = (state_reg == FULL);
    assign can_accept = !rsp_valid || rsp_ready;

    // Grants are gated by rst_n so the request side stays quiet during reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && can_accept) begin
            if (req0_valid && req1_valid) begin
                grant0 = (prio_reg == 1'b0);
                grant1 = (prio_reg == 1'b1);
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 || grant1;

    assign sel_data  = grant1 ? req1_data  : req0_data;
    assign sel_shamt = grant1 ? req1_shamt : req0_shamt;
    assign sel_op    = grant1 ? req1_op    : req0_op;

    // op[0]=0 (SLL and reserved 10) shifts left; sign only matters for right shifts.
    assign dir_left = !sel_op[0];
    assign fill_bit = !dir_left && sel_op[1] && sel_data[31];

    // Left shifts reuse the right-shift network on bit-reversed data.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rev_in
            assign shift_in[gi] = dir_left ? sel_data[31-gi] : sel_data[gi];
            assign result[gi]   = dir_left ? shift_out[31-gi] : shift_out[gi];
        end
    endgenerate

    assign stage[0] = shift_in;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = sel_shamt[gi]
                ? {{SH{fill_bit}}, stage[gi][31:SH]}
                : stage[gi];
        end
    endgenerate

    assign shift_out = stage[5];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (rsp_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            prio_reg  <= RR_INIT;
            rsp_data  <= 32'd0;
            rsp_id    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                rsp_data <= result;
                rsp_id   <= grant1;
                prio_reg <= grant0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_id) cnt1 <= cnt1 + CNT_W'(1);
            else        cnt0 <= cnt0 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: table of shift vectors plus handwritten
// round-robin, backpressure, asynchronous reset and counter-wrap sequences.
module tb_shift_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
    logic [15:0] cnt0, cnt1;

    logic        w_req0_valid, w_req0_ready, w_req1_valid, w_req1_ready;
    logic [31:0] w_req0_data, w_req1_data;
    logic [4:0]  w_req0_shamt, w_req1_shamt;
    logic [1:0]  w_req0_op, w_req1_op;
    logic        w_rsp_valid, w_rsp_ready, w_rsp_id;
    logic [31:0] w_rsp_data;
    logic [1:0]  w_cnt0, w_cnt1;

    shift_arbiter #(.RR_INIT(1'b0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_shamt(req1_shamt), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .cnt0(cnt0), .cnt1(cnt1)
    );

    shift_arbiter #(.RR_INIT(1'b1), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_data(w_req0_data),
        .req0_shamt(w_req0_shamt), .req0_op(w_req0_op),
        .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_data(w_req1_data),
        .req1_shamt(w_req1_shamt), .req1_op(w_req1_op),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_data(w_rsp_data),
        .rsp_id(w_rsp_id), .cnt0(w_cnt0), .cnt1(w_cnt1)
    );

    typedef struct {
        logic        port;
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp0  = 0;
    int   exp1  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic port, input logic [1:0] op,
                         input logic [31:0] data, input logic [4:0] shamt);
        if (port) begin
            req1_valid = 1'b1; req1_op = op; req1_data = data; req1_shamt = shamt;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_data = data; req0_shamt = shamt;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1]  = '{1'b1, 2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[2]  = '{1'b1, 2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[3]  = '{1'b1, 2'b10, 32'h8000_0000, 5'd4,  32'h0000_0000};
        vecs[4]  = '{1'b1, 2'b11, 32'h7000_0000, 5'd4,  32'h0700_0000};
        vecs[5]  = '{1'b0, 2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 2'b00, 32'h1234_5678, 5'd8,  32'h3456_7800};
        vecs[8]  = '{1'b0, 2'b01, 32'hF000_0000, 5'd31, 32'h0000_0001};
        vecs[9]  = '{1'b0, 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[10] = '{1'b1, 2'b10, 32'h0000_0003, 5'd1,  32'h0000_0006};

        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_data = '0; req0_shamt = '0; req0_op = '0;
        req1_valid = 1'b0; req1_data = '0; req1_shamt = '0; req1_op = '0;
        w_rsp_ready = 1'b1;
        w_req0_valid = 1'b0; w_req0_data = '0; w_req0_shamt = '0; w_req0_op = '0;
        w_req1_valid = 1'b0; w_req1_data = '0; w_req1_shamt = '0; w_req1_op = '0;

        // Reset state, including ready forced low while in reset.
        step(); step();
        req0_valid = 1'b1;
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_cnt0", cnt0, 0);
        chk("reset_cnt1", cnt1, 0);
        chk("reset_req0_ready", req0_ready, 0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Table vectors, one per cycle, single requester each.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].port, vecs[i].op, vecs[i].data, vecs[i].shamt);
            #1;
            chk($sformatf("vec%0d_ready", i), vecs[i].port ? req1_ready : req0_ready, 1);
            step();
            req0_valid = 1'b0; req1_valid = 1'b0;
            if (vecs[i].port) exp1++; else exp0++;
            chk($sformatf("vec%0d_valid", i), rsp_valid, 1);
            chk($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp);
            chk($sformatf("vec%0d_id", i), rsp_id, vecs[i].port);
            if (i == 1) chk("first_cnt0", cnt0, 1);
            $display("vec %0d port=%0d op=%b data=%h shamt=%0d -> %h", i, vecs[i].port,
                     vecs[i].op, vecs[i].data, vecs[i].shamt, rsp_data);
        end
        step();
        chk("table_drain_valid", rsp_valid, 0);
        chk("table_cnt0", cnt0, exp0);
        chk("table_cnt1", cnt1, exp1);

        // Round-robin with both requesters valid for six cycles.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 32'h10, 5'd0);
        drive(1'b1, 2'b01, 32'h20, 5'd0);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr%0d_ready0", k), req0_ready, (k % 2 == 0));
            chk($sformatf("rr%0d_ready1", k), req1_ready, (k % 2 == 1));
            step();
            chk($sformatf("rr%0d_id", k), rsp_id, k % 2);
            chk($sformatf("rr%0d_data", k), rsp_data, (k % 2) ? 32'h20 : 32'h10);
            $display("rr %0d id=%0d data=%h", k, rsp_id, rsp_data);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("rr_cnt0", cnt0, 3);
        chk("rr_cnt1", cnt1, 3);

        // Backpressure: held result stays put and no grant is issued.
        rsp_ready = 1'b0;
        drive(1'b0, 2'b00, 32'hA5, 5'd4);
        #1;
        chk("bp_first_ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        chk("bp_first_data", rsp_data, 32'hA50);
        drive(1'b0, 2'b00, 32'h1, 5'd1);
        drive(1'b1, 2'b00, 32'h3, 5'd2);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp%0d_ready0", k), req0_ready, 0);
            chk($sformatf("bp%0d_ready1", k), req1_ready, 0);
            step();
            chk($sformatf("bp%0d_data", k), rsp_data, 32'hA50);
            chk($sformatf("bp%0d_valid", k), rsp_valid, 1);
            $display("bp %0d held data=%h", k, rsp_data);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready1", req1_ready, 1);
        chk("bp_release_ready0", req0_ready, 0);
        step();
        chk("bp_release_data", rsp_data, 32'hC);
        chk("bp_release_id", rsp_id, 1);
        chk("bp_release_cnt0", cnt0, 4);

        // Asynchronous reset mid-cycle while FULL under backpressure.
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_data", rsp_data, 0);
        chk("arst_id", rsp_id, 0);
        chk("arst_cnt0", cnt0, 0);
        chk("arst_cnt1", cnt1, 0);
        chk("arst_ready0", req0_ready, 0);
        chk("arst_ready1", req1_ready, 0);
        rsp_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        step();
        chk("post_rst_id", rsp_id, 0);
        chk("post_rst_data", rsp_data, 32'h2);
        $display("post-reset grant id=%0d data=%h", rsp_id, rsp_data);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Narrow-counter instance: RR_INIT=1 priority, then wrap of cnt1.
        w_req0_valid = 1'b1;
        w_req1_valid = 1'b1; w_req1_data = 32'h1;
        #1;
        chk("w_init_ready1", w_req1_ready, 1);
        chk("w_init_ready0", w_req0_ready, 0);
        w_req0_valid = 1'b0;
        repeat (5) step();
        w_req1_valid = 1'b0;
        step();
        chk("w_cnt1_wrap", w_cnt1, 1);
        chk("w_cnt0", w_cnt0, 0);
        $display("wrap cnt0=%0d cnt1=%0d", w_cnt0, w_cnt1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit barrel shifter (logical/arithmetic, left/right) between two requesters, e.g. the integer ALU pipe (port 0) and the load/store alignment unit (port 1).
- Arbitrates round-robin using valid/ready handshakes on each side.
- Decodes the shift opcode into the shifter's direction and sign controls, and holds the result in a one-entry registered output buffer with backpressure.

Parameters:
- RR_INIT, 0, requester that holds priority after reset (0 or 1).
- CNT_W, 16, width of the per-requester completed-transaction counters.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 presents an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_data  input  32  requester 0 operand.
- req0_shamt  input  5  requester 0 shift amount.
- req0_op  input  2  requester 0 opcode.
- req1_valid, req1_ready, req1_data, req1_shamt, req1_op: same as port 0, for requester 1.
- rsp_valid  output  1  result buffer holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  32  shifted result.
- rsp_id  output  1  requester that issued the result.
- cnt0  output  CNT_W  results delivered to requester 0.
- cnt1  output  CNT_W  results delivered to requester 1.

Behaviour:
- Opcode decode:
  - 00 = SLL (direction left, sign 0).
  - 01 = SRL (right, sign 0).
  - 11 = SRA (right, sign 1).
  - 10 is reserved and executes as SLL.
- The sign control reaches the shifter only for right shifts; left shifts always fill with 0.
- The shifter is combinational and sits between the arbitration mux and the output buffer.
- Latency: an operation accepted in cycle N appears as rsp_valid=1 with its result in cycle N+1.
- Throughput: 1 op/cycle while rsp_ready=1.
- Buffer state machine:
  - EMPTY (rsp_valid=0): goes to FULL when any request is accepted.
  - FULL (rsp_valid=1):
    - rsp_ready=1 and a new accept: stays FULL and loads the new result.
    - rsp_ready=1 and no accept: goes to EMPTY.
    - rsp_ready=0: stays FULL, and rsp_data/rsp_id hold stable.
- can_accept = !rsp_valid | rsp_ready.
- At most one request is granted per cycle, and only when can_accept=1.
- Grant rule:
  - One valid requester: grant it.
  - Both valid: grant the requester selected by the priority pointer prio.
  - reqX_ready = grant to X; it is 0 for a requester that is not valid.
  - reqX_ready depends on rsp_ready and the reqX_valid inputs combinationally; there are no registered outputs on the request side.
- Priority update: on every accepted request, prio becomes the requester that was not granted (even if that requester was idle). With no accept, prio holds.
- Requester inputs are sampled only on the accept cycle. Changes on a non-accepted port have no effect.
- Counters:
  - cntX increments when a result with rsp_id=X is consumed (rsp_valid & rsp_ready).
  - Counters wrap from 2^CNT_W-1 to 0 without saturating.
- Shift amount 0 returns the operand unchanged for every opcode.
- Reset (asynchronous, any time, including while the buffer is FULL under backpressure):
  - rsp_valid=0, rsp_data=0, rsp_id=0, cnt0=cnt1=0, prio=RR_INIT.
  - The held result is discarded and no handshake completes in the reset cycle.
  - req0_ready/req1_ready evaluate to the grant with an empty buffer once rst_n deasserts. While rst_n=0 they are forced to 0.

Test Plan:
- Port 0 op=00, data=0x0000_0001, shamt=31; rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x8000_0000, rsp_id=0, then cnt0=1.
- Port 1 data=0x8000_0000, shamt=4: op=01 -> 0x0800_0000; op=11 -> 0xF800_0000; op=10 -> 0x0000_0000. Also data=0x7000_0000, op=11, shamt=4 -> 0x0700_0000.
- Both ports valid continuously for 6 cycles, RR_INIT=0, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1 with one result per cycle; cnt0=cnt1=3.
- Port 0 result in buffer with rsp_ready=0 for 4 cycles while both ports are valid -> req0_ready=req1_ready=0, rsp_data stable. When rsp_ready rises -> same-cycle accept of the prio requester, new result the next cycle.
- Assert rst_n=0 mid-cycle while FULL under backpressure -> rsp_valid drops immediately with no clock edge; counters and rsp_data read 0. First grant after release with both valid goes to RR_INIT.
- Set CNT_W=2 and deliver 5 results to port 1 -> cnt1 reads 1 (wrap), cnt0 reads 0.
